// File: rtl/rom_ctrl_digest_collect.sv
// Gathers the expected digest from the top ROM words and the KMAC digest, then
// pulses start_o once to launch the digest comparison.
module rom_ctrl_digest_collect #(
  parameter int unsigned NumWords = 8,
  parameter int unsigned RomAw    = 12,
  parameter int unsigned RomDepth = 4096
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     begin_i,
  output logic                     rom_req_o,
  output logic [RomAw-1:0]         rom_addr_o,
  input  logic                     rom_rvalid_i,
  input  logic [31:0]              rom_rdata_i,
  input  logic                     kmac_valid_i,
  input  logic [NumWords*32-1:0]   kmac_digest_i,
  output logic [NumWords*32-1:0]   digest_o,
  output logic [NumWords*32-1:0]   exp_digest_o,
  output logic                     start_o,
  output logic                     alert_o
);

  localparam int unsigned CntW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam logic [CntW-1:0]  CntMax   = CntW'(NumWords - 1);
  localparam logic [RomAw-1:0] BaseAddr = RomAw'(RomDepth - NumWords);

  // Sparse encoding, pairwise Hamming distance >= 3.
  typedef enum logic [4:0] {
    StIdle     = 5'b01011,
    StReadExp  = 5'b10110,
    StWaitKmac = 5'b11101,
    StDone     = 5'b00000
  } state_e;

  logic [4:0]                state_r, state_d_s;
  logic [CntW-1:0]           cnt_r, cnt_inv_r, cnt_d_s;
  logic                      outstanding_r, outstanding_d_s;
  logic                      kmac_seen_r;
  logic                      start_r;
  logic [NumWords*32-1:0]    digest_r;
  logic [NumWords-1:0][31:0] exp_r;
  logic                      rom_req_s;
  logic                      exp_we_s;
  logic                      kmac_cap_s;
  logic                      state_valid_s;
  logic                      cnt_err_s;

  // Next-state, ROM request and capture-enable decode.
  always_comb begin
    state_d_s       = state_r;
    cnt_d_s         = cnt_r;
    outstanding_d_s = outstanding_r;
    rom_req_s       = 1'b0;
    exp_we_s        = 1'b0;
    state_valid_s   = 1'b1;
    case (state_r)
      StIdle: begin
        if (begin_i) begin
          state_d_s = StReadExp;
        end else begin
          state_d_s = state_r;
        end
      end
      StReadExp: begin
        if (!outstanding_r) begin
          rom_req_s       = 1'b1;
          outstanding_d_s = 1'b1;
        end else if (rom_rvalid_i) begin
          exp_we_s        = 1'b1;
          outstanding_d_s = 1'b0;
          if (cnt_r == CntMax) begin
            state_d_s = StWaitKmac;
          end else begin
            cnt_d_s = cnt_r + CntW'(1);
          end
        end else begin
          outstanding_d_s = outstanding_r;
        end
      end
      StWaitKmac: begin
        if (kmac_seen_r || kmac_valid_i) begin
          state_d_s = StDone;
        end else begin
          state_d_s = state_r;
        end
      end
      StDone: begin
        state_d_s = state_r;
      end
      default: begin
        state_valid_s = 1'b0;
      end
    endcase
    kmac_cap_s = kmac_valid_i && !kmac_seen_r &&
                 ((state_r == StReadExp) || (state_r == StWaitKmac));
  end

  // The inverted shadow copy of the counter must always mirror the primary.
  assign cnt_err_s = (cnt_r != ~cnt_inv_r);

  assign alert_o = (begin_i && (state_r != StIdle))
                 | (rom_rvalid_i && !outstanding_r)
                 | (kmac_valid_i && ((state_r == StIdle) || (state_r == StDone) || kmac_seen_r))
                 | ((state_r == StIdle) && (cnt_r != '0))
                 | (((state_r == StWaitKmac) || (state_r == StDone)) && (cnt_r != CntMax))
                 | !state_valid_s
                 | cnt_err_s;

  assign rom_req_o    = rom_req_s;
  assign rom_addr_o   = rom_req_s ? (BaseAddr + RomAw'(cnt_r)) : '0;
  assign digest_o     = digest_r;
  assign exp_digest_o = exp_r;
  assign start_o      = start_r;

  // State, counter, handshake tracking and captured digests.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r       <= StIdle;
      cnt_r         <= '0;
      cnt_inv_r     <= '1;
      outstanding_r <= 1'b0;
      kmac_seen_r   <= 1'b0;
      start_r       <= 1'b0;
      digest_r      <= '0;
      exp_r         <= '0;
    end else begin
      state_r       <= state_d_s;
      cnt_r         <= cnt_d_s;
      cnt_inv_r     <= ~cnt_d_s;
      outstanding_r <= outstanding_d_s;
      start_r       <= (state_r == StWaitKmac) && (state_d_s == StDone);
      if (kmac_cap_s) begin
        digest_r    <= kmac_digest_i;
        kmac_seen_r <= 1'b1;
      end
      if (exp_we_s) begin
        exp_r[cnt_r] <= rom_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_rom_ctrl_digest_collect.sv
// Bench for rom_ctrl_digest_collect with two digest words and a 16-word ROM.
module tb_rom_ctrl_digest_collect;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        begin_i = 1'b0;
  logic        rom_req_o;
  logic [3:0]  rom_addr_o;
  logic        rom_rvalid_i = 1'b0;
  logic [31:0] rom_rdata_i = 32'h0;
  logic        kmac_valid_i = 1'b0;
  logic [63:0] kmac_digest_i = 64'h0;
  logic [63:0] digest_o;
  logic [63:0] exp_digest_o;
  logic        start_o;
  logic        alert_o;

  rom_ctrl_digest_collect #(.NumWords(2), .RomAw(4), .RomDepth(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .begin_i(begin_i),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o),
    .rom_rvalid_i(rom_rvalid_i), .rom_rdata_i(rom_rdata_i),
    .kmac_valid_i(kmac_valid_i), .kmac_digest_i(kmac_digest_i),
    .digest_o(digest_o), .exp_digest_o(exp_digest_o),
    .start_o(start_o), .alert_o(alert_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          kmac_c;
    logic [31:0] wa;
    logic [31:0] wb;
    logic [63:0] kd;
    logic [63:0] exp_ed;
    int          exp_start;
  } vec_t;

  typedef struct {
    logic [63:0] ed;
    logic [63:0] kd;
  } res_t;

  vec_t        vecs[6];
  res_t        res_q[$];
  logic [3:0]  addr_q[$];
  logic [31:0] rom_mem[16];
  int          n_vec = 0;
  int          n_err = 0;
  int          start_cyc;
  int          start_cnt;
  int          alert_seen;
  int          viol;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    begin_i = 1'b0; rom_rvalid_i = 1'b0; rom_rdata_i = 32'h0;
    kmac_valid_i = 1'b0; kmac_digest_i = 64'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_req", 64'(rom_req_o), 64'h0);
    chk("rst_addr", 64'(rom_addr_o), 64'h0);
    chk("rst_digest", digest_o, 64'h0);
    chk("rst_exp", exp_digest_o, 64'h0);
    chk("rst_start", 64'(start_o), 64'h0);
    chk("rst_alert", 64'(alert_o), 64'h0);
  endtask

  // Issue begin_i, act as ROM with latency lat, send KMAC at cycle kc; bounded by ncyc.
  task automatic serve(input int lat, input int kc, input logic [63:0] kd, input int ncyc);
    bit pend = 1'b0;
    bit prev_req = 1'b0;
    int wait_c = 0;
    logic [3:0] pend_addr = 4'h0;
    start_cyc = -1; start_cnt = 0; alert_seen = 0; viol = 0;
    addr_q.push_back(4'd14);
    addr_q.push_back(4'd15);
    for (int c = 0; c < ncyc; c++) begin
      begin_i = (c == 0);
      rom_rvalid_i = 1'b0;
      rom_rdata_i = 32'h0;
      if (pend) begin
        if (wait_c == 0) begin
          rom_rvalid_i = 1'b1;
          rom_rdata_i = rom_mem[pend_addr];
          pend = 1'b0;
        end else begin
          wait_c--;
        end
      end
      kmac_valid_i = (c == kc);
      kmac_digest_i = (c == kc) ? kd : 64'h0;
      #1;
      if (alert_o) alert_seen++;
      if (rom_req_o) begin
        if (pend || prev_req) viol++;
        pend = 1'b1;
        wait_c = lat - 1;
        pend_addr = rom_addr_o;
        if (addr_q.size() == 0) begin
          chk("extra_req", 64'(rom_addr_o), 64'hFFFF);
        end else begin
          chk("req_addr", 64'(rom_addr_o), 64'(addr_q.pop_front()));
        end
      end
      prev_req = rom_req_o;
      if (start_o) begin
        start_cnt++;
        if (start_cyc < 0) start_cyc = c;
        if (res_q.size() == 0) begin
          chk("unexpected_start", 64'(start_o), 64'h0);
        end else begin
          res_t r = res_q.pop_front();
          chk("exp_digest", exp_digest_o, r.ed);
          chk("digest", digest_o, r.kd);
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic run_vec(input int v);
    res_t r;
    rom_mem[14] = vecs[v].wa;
    rom_mem[15] = vecs[v].wb;
    r.ed = vecs[v].exp_ed;
    r.kd = vecs[v].kd;
    res_q.push_back(r);
    serve(vecs[v].lat, vecs[v].kmac_c, vecs[v].kd, 16);
    chk("start_cycle", 64'(start_cyc), 64'(vecs[v].exp_start));
    chk("start_pulses", 64'(start_cnt), 64'h1);
    chk("alert_clean", 64'(alert_seen), 64'h0);
    chk("req_protocol", 64'(viol), 64'h0);
    chk("addr_drained", 64'(addr_q.size()), 64'h0);
    addr_q.delete();
    res_q.delete();
  endtask

  initial begin
    vecs[0] = '{1, 2, 32'hAAAA_0001, 32'hBBBB_0002, 64'hD1D1_1111_D0D0_0000, 64'hBBBB_0002_AAAA_0001, 6};
    vecs[1] = '{1, 4, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0F0F_0F0F_F0F0_F0F0, 64'h9ABC_DEF0_1234_5678, 6};
    vecs[2] = '{1, 8, 32'hDEAD_BEEF, 32'hCAFE_F00D, 64'h0123_4567_89AB_CDEF, 64'hCAFE_F00D_DEAD_BEEF, 9};
    vecs[3] = '{3, 1, 32'h0000_0001, 32'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 10};
    vecs[4] = '{2, 8, 32'h5555_5555, 32'hAAAA_AAAA, 64'h0000_0001_0000_0002, 64'hAAAA_AAAA_5555_5555, 9};
    vecs[5] = '{3, 5, 32'hFFFF_FFFF, 32'h0000_0000, 64'h8765_4321_1357_9BDF, 64'h0000_0000_FFFF_FFFF, 10};
    for (int i = 0; i < 16; i++) rom_mem[i] = 32'h0;

    for (int v = 0; v < 6; v++) begin
      do_reset();
      run_vec(v);
    end

    // KMAC before begin_i, then simultaneous begin_i and kmac_valid_i in Idle.
    do_reset();
    kmac_valid_i = 1'b1; kmac_digest_i = 64'h1111_2222_3333_4444;
    #1 chk("early_kmac_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1 chk("early_kmac_nocap", digest_o, 64'h0);
    chk("idle_quiet", 64'(alert_o), 64'h0);
    begin_i = 1'b1; kmac_valid_i = 1'b1; kmac_digest_i = 64'h5555_6666_7777_8888;
    #1 chk("simul_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1 chk("simul_begin_req", 64'(rom_req_o), 64'h1);
    chk("simul_begin_addr", 64'(rom_addr_o), 64'd14);
    chk("simul_nocap", digest_o, 64'h0);

    // Protocol violations while waiting for KMAC and after Done.
    do_reset();
    rom_mem[14] = 32'h0A0A_0A0A; rom_mem[15] = 32'h0B0B_0B0B;
    serve(1, -1, 64'h0, 6);
    addr_q.delete();
    begin_i = 1'b1;
    #1 chk("begin_in_wait_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1 chk("wait_no_restart", 64'(rom_req_o), 64'h0);
    rom_rvalid_i = 1'b1; rom_rdata_i = 32'hBAD0_BAD0;
    #1 chk("stray_rvalid_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1 chk("exp_kept", exp_digest_o, 64'h0B0B_0B0B_0A0A_0A0A);
    kmac_valid_i = 1'b1; kmac_digest_i = 64'hC0DE_C0DE_FACE_FACE;
    #1 chk("wait_kmac_ok", 64'(alert_o), 64'h0);
    @(negedge clk);
    clear_inputs();
    #1 chk("done_start", 64'(start_o), 64'h1);
    chk("done_digest", digest_o, 64'hC0DE_C0DE_FACE_FACE);
    kmac_valid_i = 1'b1; kmac_digest_i = 64'h9999_9999_9999_9999;
    #1 chk("second_kmac_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    clear_inputs();
    #1 chk("no_recapture", digest_o, 64'hC0DE_C0DE_FACE_FACE);
    chk("start_once", 64'(start_o), 64'h0);

    // Corrupted state encoding and counter shadow.
    do_reset();
    force dut.state_r = 5'b11111;
    #1 chk("bad_state_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    #1 chk("bad_state_nostart", 64'(start_o), 64'h0);
    release dut.state_r;
    do_reset();
    force dut.cnt_inv_r = 1'b0;
    #1 chk("cnt_err_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    #1 chk("cnt_err_nostart", 64'(start_o), 64'h0);
    release dut.cnt_inv_r;

    // Reset in the middle of ReadExp with a read outstanding.
    do_reset();
    rom_mem[14] = vecs[0].wa; rom_mem[15] = vecs[0].wb;
    serve(3, -1, 64'h0, 3);
    addr_q.delete();
    rst_ni = 1'b0;
    #1 chk("midrst_req", 64'(rom_req_o), 64'h0);
    chk("midrst_exp", exp_digest_o, 64'h0);
    chk("midrst_alert", 64'(alert_o), 64'h0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    rom_rvalid_i = 1'b1; rom_rdata_i = 32'h1357_2468;
    #1 chk("stale_rvalid_alert", 64'(alert_o), 64'h1);
    @(negedge clk);
    clear_inputs();
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
